// File: rtl/data_receive_engine.sv
`default_nettype none
// ============================================================================
// Module      : data_receive_engine
// Description : Sink end of the byte-serial link. Accepts DATA_SIZE chunks of
//               DATA_WIDTH bits over a valid/ready handshake and assembles them
//               (first chunk in the LSBs) into one packet. Latches the source and
//               destination addresses, and reports completion, progress and
//               sticky error status (bad addresses, abort, idle timeout).
// Ports       : clk_i, reset_i (async, active-high)
//               start_i, src_address_i, dst_address_i  - packet start request
//               data_in_i, valid_i, ready_o            - byte handshake
//               data_out_o, src_address_o, dst_address_o, count_o
//               done_o (one-cycle pulse), error_o (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module data_receive_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             start_i,
    input  logic [15:0]                      src_address_i,
    input  logic [15:0]                      dst_address_i,
    input  logic [DATA_WIDTH-1:0]            data_in_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic [DATA_SIZE*DATA_WIDTH-1:0]  data_out_o,
    output logic [15:0]                      src_address_o,
    output logic [15:0]                      dst_address_o,
    output logic [$clog2(DATA_SIZE):0]       count_o,
    output logic                             done_o,
    output logic                             error_o
);

    localparam int c_CNT_W  = $clog2(DATA_SIZE) + 1;
    localparam int c_PKT_W  = DATA_SIZE * DATA_WIDTH;
    // A zero TIMEOUT still needs a legal (1-bit) counter even though it is unused.
    localparam int c_IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(DATA_SIZE - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = {c_IDLE_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_IDLE_W-1:0]   r_idle_cnt;
    logic [c_IDLE_W-1:0]   w_idle_nxt;
    logic                  w_ready_nxt;
    logic [c_PKT_W-1:0]    w_data_nxt;
    logic [15:0]           w_src_nxt;
    logic [15:0]           w_dst_nxt;
    logic [c_CNT_W-1:0]    w_count_nxt;
    logic                  w_done_nxt;
    logic                  w_error_nxt;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Every output is registered, so this
    // block computes the value each output register takes on the next edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle_cnt;
        w_ready_nxt = 1'b0;
        w_data_nxt  = data_out_o;
        w_src_nxt   = src_address_o;
        w_dst_nxt   = dst_address_o;
        w_count_nxt = count_o;
        w_done_nxt  = 1'b0;
        w_error_nxt = error_o;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                // DONE lasts one cycle; ERROR is held until a start arrives.
                if (r_state == S_DONE) begin
                    w_state_nxt = S_IDLE;
                end
                if (start_i) begin
                    w_src_nxt = src_address_i;
                    w_dst_nxt = dst_address_i;
                    if (src_address_i == dst_address_i) begin
                        // Addresses are kept for diagnosis; packet data is untouched.
                        w_state_nxt = S_ERROR;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RECV;
                        w_ready_nxt = 1'b1;
                        w_data_nxt  = '0;
                        w_count_nxt = '0;
                        w_error_nxt = 1'b0;
                        w_idle_nxt  = '0;
                    end
                end
            end

            S_RECV: begin
                if (start_i) begin
                    // Abort: a concurrent byte is dropped and the count frozen.
                    w_state_nxt = S_ERROR;
                    w_error_nxt = 1'b1;
                end else if (valid_i && ready_o) begin
                    for (int k = 0; k < DATA_SIZE; k++) begin
                        if (count_o == c_CNT_W'(k)) begin
                            w_data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = data_in_i;
                        end
                    end
                    w_count_nxt = count_o + c_CNT_W'(1);
                    w_idle_nxt  = '0;
                    if (count_o == c_CNT_LAST) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_ready_nxt = 1'b1;
                    end
                end else begin
                    if (r_idle_cnt != c_IDLE_MAX) begin
                        w_idle_nxt = r_idle_cnt + c_IDLE_W'(1);
                    end
                    // This edge completes the TIMEOUT-th consecutive idle cycle.
                    if ((TIMEOUT != 0) && (r_idle_cnt == c_IDLE_LAST)) begin
                        w_state_nxt = S_ERROR;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_ready_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= S_IDLE;
            r_idle_cnt    <= '0;
            ready_o       <= 1'b0;
            data_out_o    <= '0;
            src_address_o <= '0;
            dst_address_o <= '0;
            count_o       <= '0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idle_cnt    <= w_idle_nxt;
            ready_o       <= w_ready_nxt;
            data_out_o    <= w_data_nxt;
            src_address_o <= w_src_nxt;
            dst_address_o <= w_dst_nxt;
            count_o       <= w_count_nxt;
            done_o        <= w_done_nxt;
            error_o       <= w_error_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_receive_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_receive_engine
// Description : Self-checking bench for data_receive_engine. Stimulus pushes
//               the expected packet/error snapshot into a queue; a monitor pops
//               and compares whenever done_o pulses or error_o rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_receive_engine;

    localparam int DW = 8;
    localparam int DS = 32;
    localparam int TO = 64;
    localparam int PW = DS * DW;
    localparam int CW = $clog2(DS) + 1;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [15:0]   src_address_i;
    logic [15:0]   dst_address_i;
    logic [DW-1:0] data_in_i;
    logic          valid_i;
    logic          ready_o;
    logic [PW-1:0] data_out_o;
    logic [15:0]   src_address_o;
    logic [15:0]   dst_address_o;
    logic [CW-1:0] count_o;
    logic          done_o;
    logic          error_o;

    data_receive_engine #(
        .DATA_WIDTH (DW),
        .DATA_SIZE  (DS),
        .TIMEOUT    (TO)
    ) u_dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .src_address_i (src_address_i),
        .dst_address_i (dst_address_i),
        .data_in_i     (data_in_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_out_o    (data_out_o),
        .src_address_o (src_address_o),
        .dst_address_o (dst_address_o),
        .count_o       (count_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit            err;
        logic [PW-1:0] data;
        int            count;
        logic [15:0]   src;
        logic [15:0]   dst;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model: what the packet registers should hold right now.
    logic [PW-1:0] m_data  = '0;
    int            m_count = 0;
    logic [15:0]   m_src   = '0;
    logic [15:0]   m_dst   = '0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input bit err);
        ev_t e;
        e.err   = err;
        e.data  = m_data;
        e.count = m_count;
        e.src   = m_src;
        e.dst   = m_dst;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_pkt(input logic [15:0] src, input logic [15:0] dst);
        start_i       = 1'b1;
        src_address_i = src;
        dst_address_i = dst;
        m_src = src;
        m_dst = dst;
        if (src == dst) begin
            push_ev(1'b1);
        end else begin
            m_data  = '0;
            m_count = 0;
        end
        tick();
        start_i = 1'b0;
    endtask

    // gap < 0 selects a random 0..3 cycle gap after each byte.
    task automatic send_bytes(input int n, input int gap, input bit incr);
        int g;
        for (int k = 0; k < n; k++) begin
            valid_i   = 1'b1;
            data_in_i = incr ? DW'(m_count) : DW'($urandom);
            m_data[m_count*DW +: DW] = data_in_i;
            m_count++;
            if (m_count == DS) push_ev(1'b0);
            tick();
            valid_i   = 1'b0;
            data_in_i = DW'($urandom);
            if (m_count != DS) begin
                g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                repeat (g) tick();
            end
        end
    endtask

    function automatic logic [15:0] other_addr(input logic [15:0] a);
        return a + 16'($urandom_range(1, 65535));
    endfunction

    task automatic random_packet();
        logic [15:0] s;
        s = 16'($urandom);
        start_pkt(s, other_addr(s));
        send_bytes(DS, -1, 1'b0);
        check("rand_done", 256'(done_o), 256'(1));
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 256'(ready_o), 256'(0));
        check({tag, "_data"},  data_out_o, '0);
        check({tag, "_src"},   256'(src_address_o), 256'(0));
        check({tag, "_dst"},   256'(dst_address_o), 256'(0));
        check({tag, "_count"}, 256'(count_o), 256'(0));
        check({tag, "_done"},  256'(done_o), 256'(0));
        check({tag, "_error"}, 256'(error_o), 256'(0));
    endtask

    // Monitor: one expected event per done pulse or error rising edge.
    initial begin : monitor
        logic prev_err;
        ev_t  e;
        prev_err = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!reset_i && (done_o || (error_o && !prev_err))) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: actual done=%0b error=%0b required=no event", done_o, error_o);
                end else begin
                    e = q.pop_front();
                    check("ev_kind",  256'(error_o), 256'(e.err));
                    check("ev_data",  data_out_o, e.data);
                    check("ev_count", 256'(count_o), 256'(e.count));
                    check("ev_src",   256'(src_address_o), 256'(e.src));
                    check("ev_dst",   256'(dst_address_o), 256'(e.dst));
                    check("ev_ready", 256'(ready_o), 256'(0));
                end
            end
            prev_err = error_o;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=still running required=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          n;
        logic [15:0] s;

        reset_i       = 1'b1;
        start_i       = 1'b0;
        src_address_i = '0;
        dst_address_i = '0;
        data_in_i     = '0;
        valid_i       = 1'b0;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        check("idle_ready", 256'(ready_o), 256'(0));

        // 1: back-to-back incrementing packet.
        start_pkt(16'h1000, 16'h2000);
        check("t1_ready", 256'(ready_o), 256'(1));
        send_bytes(DS, 0, 1'b1);
        check("t1_done",  256'(done_o), 256'(1));
        check("t1_data",  data_out_o, 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100);
        check("t1_count", 256'(count_o), 256'(32));
        check("t1_error", 256'(error_o), 256'(0));
        tick();
        check("t1_pulse", 256'(done_o), 256'(0));

        // 2: same packet with 3-cycle gaps, then hold until the next start.
        start_pkt(16'h1000, 16'h2000);
        send_bytes(DS, 3, 1'b1);
        check("t2_done", 256'(done_o), 256'(1));
        repeat (6) tick();
        check("t2_hold_data",  data_out_o, m_data);
        check("t2_hold_count", 256'(count_o), 256'(32));
        check("t2_hold_done",  256'(done_o), 256'(0));
        random_packet();

        // 3: timeout after 5 bytes.
        s = 16'($urandom);
        start_pkt(s, other_addr(s));
        send_bytes(5, 0, 1'b0);
        push_ev(1'b1);
        n = 0;
        while (!error_o && n < 4 * TO) begin
            tick();
            n++;
        end
        check("t3_idle_cycles", 256'(n), 256'(TO));
        check("t3_count", 256'(count_o), 256'(5));
        check("t3_ready", 256'(ready_o), 256'(0));
        valid_i = 1'b1;
        repeat (3) tick();
        valid_i = 1'b0;
        check("t3_ignored", 256'(count_o), 256'(5));
        s = 16'($urandom);
        start_pkt(s, other_addr(s));
        check("t3_err_clear", 256'(error_o), 256'(0));
        send_bytes(DS, -1, 1'b0);
        tick();

        // 4: abort with a concurrent byte after 10 bytes.
        s = 16'($urandom);
        start_pkt(s, other_addr(s));
        send_bytes(10, -1, 1'b0);
        start_i       = 1'b1;
        valid_i       = 1'b1;
        data_in_i     = DW'($urandom);
        src_address_i = m_src;
        dst_address_i = m_dst;
        push_ev(1'b1);
        tick();
        start_i = 1'b0;
        valid_i = 1'b0;
        check("t4_count", 256'(count_o), 256'(10));
        check("t4_error", 256'(error_o), 256'(1));
        check("t4_done",  256'(done_o), 256'(0));
        repeat (2) tick();
        random_packet();

        // 5: equal addresses from IDLE.
        start_pkt(16'h00AA, 16'h00AA);
        check("t5_error", 256'(error_o), 256'(1));
        for (int k = 0; k < 4; k++) begin
            valid_i   = 1'b1;
            data_in_i = DW'($urandom);
            tick();
            check("t5_ready", 256'(ready_o), 256'(0));
            check("t5_count", 256'(count_o), 256'(m_count));
        end
        valid_i = 1'b0;
        check("t5_data", data_out_o, m_data);

        // 6: asynchronous reset mid-packet, then a clean packet.
        s = 16'($urandom);
        start_pkt(s, other_addr(s));
        send_bytes(20, 0, 1'b0);
        #3;
        reset_i = 1'b1;
        #1;
        check_all_zero("t6_async");
        m_data  = '0;
        m_count = 0;
        m_src   = '0;
        m_dst   = '0;
        tick();
        reset_i = 1'b0;
        check("t6_count_after", 256'(count_o), 256'(0));
        random_packet();

        repeat (3) random_packet();
        repeat (5) tick();
        check("queue_empty", 256'(q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
